// File: rtl/riscv_lsu.sv
// Load/store unit between the core datapath and a valid/ready data memory.
// Handles lane steering, load extension, alignment checks, bus errors and a wait-state timeout.
module riscv_lsu #(
    parameter int XLEN           = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [XLEN-1:0]       req_wdata,
    output logic                  stall,
    output logic                  rsp_valid,
    output logic [XLEN-1:0]       rsp_rdata,
    output logic [1:0]            rsp_err,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [XLEN/8-1:0]     mem_be,
    output logic [XLEN-1:0]       mem_wdata,
    input  logic [XLEN-1:0]       mem_rdata,
    input  logic                  mem_err
);
    localparam int NB  = XLEN / 8;
    localparam int OFS = $clog2(NB);
    localparam int CW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t          state, state_next;
    logic [2:0]      funct_q;
    logic [OFS-1:0]  ofs_q;
    logic [CW-1:0]   tmo_cnt;

    logic [3:0]      req_bytes;
    logic [OFS-1:0]  req_ofs;
    logic            req_illegal, req_misaligned, req_bad;
    logic [NB-1:0]   be_calc;
    logic [XLEN-1:0] wdata_calc;
    logic            timeout_hit;

    // Low nbytes*8 bits set; a shift by the full width yields all ones after the subtract.
    function automatic logic [XLEN-1:0] size_mask(input logic [3:0] nbytes);
        return (XLEN'(1) << {nbytes, 3'b000}) - XLEN'(1);
    endfunction

    function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] rdata,
                                                    input logic [OFS-1:0]  ofs,
                                                    input logic [2:0]      funct);
        logic [XLEN-1:0] d;
        logic [XLEN-1:0] m;
        logic            sgn;
        d   = rdata >> {ofs, 3'b000};
        m   = size_mask(4'd1 << funct[1:0]);
        sgn = ~funct[2] & (|(d & m & ~(m >> 1)));
        return (d & m) | (sgn ? ~m : '0);
    endfunction

    always_comb begin
        req_ofs        = req_addr[OFS-1:0];
        req_bytes      = 4'd1 << req_funct[1:0];
        req_illegal    = (req_funct == 3'b111) ||
                         ((XLEN == 32) && (req_funct == 3'b011 || req_funct == 3'b110));
        req_misaligned = |(req_addr[3:0] & (req_bytes - 4'd1));
        req_bad        = req_illegal || req_misaligned;
        be_calc        = NB'((16'd1 << req_bytes) - 16'd1) << req_ofs;
        wdata_calc     = (req_wdata & size_mask(req_bytes)) << {req_ofs, 3'b000};
        timeout_hit    = (TIMEOUT_CYCLES > 0) && (state == REQ) && !mem_ready &&
                         (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        stall      = 1'b1;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                stall     = 1'b0;
                if (req_valid) state_next = req_bad ? RESP : REQ;
            end
            REQ:     if (mem_ready || timeout_hit) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 2'b00;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            tmo_cnt   <= '0;
            funct_q   <= '0;
            ofs_q     <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    funct_q <= req_funct;
                    ofs_q   <= req_ofs;
                    tmo_cnt <= '0;
                    if (req_bad) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 2'b01;
                        rsp_rdata <= '0;
                    end else begin
                        mem_valid <= 1'b1;
                        mem_we    <= req_we;
                        mem_addr  <= {req_addr[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};
                        mem_be    <= be_calc;
                        mem_wdata <= wdata_calc;
                    end
                end
                // A ready in the same cycle the limit is reached takes priority over the timeout.
                REQ: if (mem_ready) begin
                    mem_valid <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_err   <= mem_err ? 2'b10 : 2'b00;
                    rsp_rdata <= (mem_err || mem_we) ? '0 : load_extend(mem_rdata, ofs_q, funct_q);
                end else if (timeout_hit) begin
                    mem_valid <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 2'b11;
                    rsp_rdata <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: 32-bit and 64-bit instances, both with an 8-cycle timeout,
// driven by directed spec vectors and random accesses checked against a byte-level model.
module tb_riscv_lsu;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        req_valid, req_we;
    logic [2:0]  req_funct;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic        mem_ready, mem_err;
    logic [63:0] mem_rdata;

    logic        a_req_ready, a_stall, a_rsp_valid, a_mem_valid, a_mem_we;
    logic [31:0] a_rsp_rdata, a_mem_addr, a_mem_wdata;
    logic [1:0]  a_rsp_err;
    logic [3:0]  a_mem_be;
    logic        b_req_ready, b_stall, b_rsp_valid, b_mem_valid, b_mem_we;
    logic [63:0] b_rsp_rdata, b_mem_wdata;
    logic [31:0] b_mem_addr;
    logic [1:0]  b_rsp_err;
    logic [7:0]  b_mem_be;

    logic        o_req_ready, o_stall, o_rsp_valid, o_mem_valid, o_mem_we;
    logic [63:0] o_rsp_rdata, o_mem_wdata;
    logic [31:0] o_mem_addr;
    logic [1:0]  o_rsp_err;
    logic [7:0]  o_mem_be;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    riscv_lsu #(.XLEN(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut32 (
        .clk(clk), .reset(reset), .req_valid(req_valid & ~sel), .req_ready(a_req_ready),
        .req_we(req_we), .req_funct(req_funct), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
        .stall(a_stall), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
        .mem_valid(a_mem_valid), .mem_ready(mem_ready & ~sel), .mem_we(a_mem_we),
        .mem_addr(a_mem_addr), .mem_be(a_mem_be), .mem_wdata(a_mem_wdata),
        .mem_rdata(mem_rdata[31:0]), .mem_err(mem_err));

    riscv_lsu #(.XLEN(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut64 (
        .clk(clk), .reset(reset), .req_valid(req_valid & sel), .req_ready(b_req_ready),
        .req_we(req_we), .req_funct(req_funct), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(b_stall), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .mem_valid(b_mem_valid), .mem_ready(mem_ready & sel), .mem_we(b_mem_we),
        .mem_addr(b_mem_addr), .mem_be(b_mem_be), .mem_wdata(b_mem_wdata),
        .mem_rdata(mem_rdata), .mem_err(mem_err));

    always_comb begin
        o_req_ready = sel ? b_req_ready : a_req_ready;
        o_stall     = sel ? b_stall     : a_stall;
        o_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
        o_rsp_rdata = sel ? b_rsp_rdata : {32'b0, a_rsp_rdata};
        o_rsp_err   = sel ? b_rsp_err   : a_rsp_err;
        o_mem_valid = sel ? b_mem_valid : a_mem_valid;
        o_mem_we    = sel ? b_mem_we    : a_mem_we;
        o_mem_addr  = sel ? b_mem_addr  : a_mem_addr;
        o_mem_be    = sel ? b_mem_be    : {4'b0, a_mem_be};
        o_mem_wdata = sel ? b_mem_wdata : {32'b0, a_mem_wdata};
    end

    // Byte-by-byte reference of what the access should look like on both sides.
    function automatic void model(input int xlen, input logic [2:0] f, input logic [31:0] addr,
                                  input logic [63:0] wd, input logic [63:0] rd,
                                  output bit bad, output logic [7:0] be,
                                  output logic [63:0] mwd, output logic [63:0] ld);
        int nb = xlen / 8;
        int sz = 1 << f[1:0];
        int o  = int'(addr % nb);
        bad = (f == 3'd7) || (xlen == 32 && (f == 3'd3 || f == 3'd6)) || (addr % sz != 0);
        be = '0; mwd = '0; ld = '0;
        if (!bad) begin
            for (int i = 0; i < sz; i++) begin
                be[o + i] = 1'b1;
                mwd[8*(o+i) +: 8] = wd[8*i +: 8];
                ld[8*i +: 8] = rd[8*(o+i) +: 8];
            end
            if (!f[2] && rd[8*(o+sz)-1])
                for (int i = sz; i < nb; i++) ld[8*i +: 8] = 8'hFF;
        end
    endfunction

    task automatic do_access(input bit x64, input bit we, input logic [2:0] f, input logic [31:0] addr,
                             input logic [63:0] wd, input logic [63:0] rd, input int delay, input bit merr,
                             output logic [63:0] got_rdata, output logic [1:0] got_err,
                             output logic [7:0] got_be, output logic [63:0] got_wdata);
        bit          bad, done;
        logic [7:0]  e_be;
        logic [63:0] e_wd, e_ld, e_rd;
        logic [1:0]  e_err;
        int          mv_cnt, e_cnt;
        model(x64 ? 64 : 32, f, addr, wd, rd, bad, e_be, e_wd, e_ld);
        if (bad)              e_err = 2'b01;
        else if (delay < TMO) e_err = merr ? 2'b10 : 2'b00;
        else                  e_err = 2'b11;
        e_rd  = (e_err != 2'b00 || we) ? 64'd0 : e_ld;
        e_cnt = (delay < TMO) ? delay + 1 : TMO;
        got_be = '0; got_wdata = '0;
        sel = x64;
        @(negedge clk);
        n_checks++;
        if (o_req_ready !== 1'b1 || o_stall !== 1'b0)
            $display("FAIL idle_ready x64=%0d: ready=%b stall=%b, want 1/0", x64, o_req_ready, o_stall);
        if (o_req_ready !== 1'b1 || o_stall !== 1'b0) n_fail++;
        req_valid = 1'b1; req_we = we; req_funct = f; req_addr = addr; req_wdata = wd;
        mem_ready = 1'b0; mem_err = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0; req_wdata = {$urandom, $urandom}; req_addr = $urandom;
        mv_cnt = 0; done = 1'b0;
        if (!bad) begin
            for (int c = 1; c <= TMO + 2 && !done; c++) begin
                mem_ready = (c == delay + 1);
                mem_err   = mem_ready & merr;
                mem_rdata = mem_ready ? rd : {$urandom, $urandom};
                @(negedge clk);
                if (o_mem_valid === 1'b1) mv_cnt++;
                if (c == 1) begin
                    got_be = o_mem_be; got_wdata = o_mem_wdata;
                    n_checks++;
                    if (o_mem_addr !== (addr & (x64 ? ~32'h7 : ~32'h3)) || o_mem_be !== e_be ||
                        o_mem_we !== we || (we && o_mem_wdata !== e_wd)) begin
                        n_fail++;
                        $display("FAIL mem_req f=%0d a=%h: addr=%h be=%h we=%b wd=%h, want be=%h we=%b wd=%h",
                                 f, addr, o_mem_addr, o_mem_be, o_mem_we, o_mem_wdata, e_be, we, e_wd);
                    end
                end
                n_checks++;
                if (o_rsp_valid !== 1'b0 || o_stall !== 1'b1 || o_req_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL req_phase c=%0d: rsp_valid=%b stall=%b ready=%b, want 0/1/0",
                             c, o_rsp_valid, o_stall, o_req_ready);
                end
                done = mem_ready || (c == TMO);
                @(posedge clk); #1;
            end
            mem_ready = 1'b0; mem_err = 1'b0;
        end
        n_checks++;
        if (mv_cnt != (bad ? 0 : e_cnt)) begin
            n_fail++;
            $display("FAIL mem_valid_cycles f=%0d: got %0d, want %0d", f, mv_cnt, bad ? 0 : e_cnt);
        end
        @(negedge clk);
        got_rdata = o_rsp_rdata; got_err = o_rsp_err;
        n_checks++;
        if (o_rsp_valid !== 1'b1 || o_rsp_err !== e_err || o_rsp_rdata !== e_rd || o_mem_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rsp f=%0d a=%h: valid=%b err=%b rdata=%h mv=%b, want 1 %b %h 0",
                     f, addr, o_rsp_valid, o_rsp_err, o_rsp_rdata, o_mem_valid, e_err, e_rd);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1 || o_rsp_rdata !== e_rd || o_rsp_err !== e_err) begin
            n_fail++;
            $display("FAIL rsp_hold: valid=%b ready=%b rdata=%h err=%b, want 0 1 %h %b",
                     o_rsp_valid, o_req_ready, o_rsp_rdata, o_rsp_err, e_rd, e_err);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            @(negedge clk);
            n_checks++;
            if ({o_req_ready, o_stall, o_rsp_valid, o_rsp_err, o_mem_valid, o_mem_we} !== 7'b1000000 ||
                o_rsp_rdata !== 64'd0 || o_mem_addr !== 32'd0 || o_mem_be !== 8'd0 || o_mem_wdata !== 64'd0) begin
                n_fail++;
                $display("FAIL reset_state x64=%0d: rdy=%b st=%b rv=%b err=%b mv=%b we=%b rd=%h a=%h be=%h wd=%h",
                         s, o_req_ready, o_stall, o_rsp_valid, o_rsp_err, o_mem_valid, o_mem_we,
                         o_rsp_rdata, o_mem_addr, o_mem_be, o_mem_wdata);
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_directed32();
        logic [63:0] rd, wd;
        logic [1:0]  err;
        logic [7:0]  be;
        do_access(0, 0, 3'b000, 32'h1003, 64'd0, 64'h80FF_1234, 0, 0, rd, err, be, wd);
        n_checks++;
        if (rd !== 64'hFFFF_FF80 || err !== 2'b00 || be !== 8'b1000) begin
            n_fail++; $display("FAIL lb: rdata=%h err=%b be=%b, want ffffff80 00 1000", rd, err, be);
        end
        do_access(0, 0, 3'b100, 32'h1003, 64'd0, 64'h80FF_1234, 0, 0, rd, err, be, wd);
        n_checks++;
        if (rd !== 64'h0000_0080) begin
            n_fail++; $display("FAIL lbu: rdata=%h, want 00000080", rd);
        end
        do_access(0, 1, 3'b001, 32'h2002, 64'h1234_ABCD, 64'hFFFF_FFFF, 0, 0, rd, err, be, wd);
        n_checks++;
        if (wd !== 64'hABCD_0000 || be !== 8'b1100 || rd !== 64'd0 || err !== 2'b00) begin
            n_fail++; $display("FAIL sh: wdata=%h be=%b rdata=%h err=%b, want abcd0000 1100 0 00", wd, be, rd, err);
        end
        do_access(0, 0, 3'b010, 32'h1001, 64'd0, 64'd0, 0, 0, rd, err, be, wd);
        n_checks++;
        if (err !== 2'b01) begin n_fail++; $display("FAIL lw_misaligned: err=%b, want 01", err); end
        do_access(0, 0, 3'b011, 32'h1000, 64'd0, 64'd0, 0, 0, rd, err, be, wd);
        n_checks++;
        if (err !== 2'b01) begin n_fail++; $display("FAIL ld_on_rv32: err=%b, want 01", err); end
    endtask

    task automatic test_timeout();
        logic [63:0] rd, wd;
        logic [1:0]  err;
        logic [7:0]  be;
        do_access(0, 0, 3'b010, 32'h3000, 64'd0, 64'h1111_2222, 50, 0, rd, err, be, wd);
        n_checks++;
        if (err !== 2'b11 || rd !== 64'd0) begin
            n_fail++; $display("FAIL timeout: err=%b rdata=%h, want 11 0", err, rd);
        end
        do_access(0, 0, 3'b010, 32'h3000, 64'd0, 64'h1111_2222, TMO - 1, 0, rd, err, be, wd);
        n_checks++;
        if (err !== 2'b00 || rd !== 64'h1111_2222) begin
            n_fail++; $display("FAIL ready_at_limit: err=%b rdata=%h, want 00 11112222", err, rd);
        end
    endtask

    task automatic test_reset_abort();
        logic [63:0] rd, wd;
        logic [1:0]  err;
        logic [7:0]  be;
        sel = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct = 3'b010; req_addr = 32'h0000_0100;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (o_mem_valid !== 1'b0 || o_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL abort_state: mem_valid=%b req_ready=%b, want 0 1", o_mem_valid, o_req_ready);
        end
        mem_ready = 1'b1; mem_rdata = 64'h5555_AAAA;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            mem_ready = 1'b0;
            @(negedge clk);
            n_checks++;
            if (o_rsp_valid !== 1'b0) begin
                n_fail++; $display("FAIL abort_no_rsp cycle %0d: rsp_valid=%b, want 0", i, o_rsp_valid);
            end
        end
        do_access(0, 0, 3'b010, 32'h0000_0100, 64'd0, 64'hCAFE_F00D, 3, 0, rd, err, be, wd);
        n_checks++;
        if (rd !== 64'hCAFE_F00D || err !== 2'b00) begin
            n_fail++; $display("FAIL after_abort: rdata=%h err=%b, want cafef00d 00", rd, err);
        end
    endtask

    task automatic test_directed64();
        logic [63:0] rd, wd;
        logic [1:0]  err;
        logic [7:0]  be;
        do_access(1, 0, 3'b110, 32'hC, 64'd0, 64'hDEAD_BEEF_0000_0000, 1, 0, rd, err, be, wd);
        n_checks++;
        if (rd !== 64'h0000_0000_DEAD_BEEF || be !== 8'hF0 || err !== 2'b00) begin
            n_fail++; $display("FAIL lwu64: rdata=%h be=%h err=%b, want 00000000deadbeef f0 00", rd, be, err);
        end
        do_access(1, 0, 3'b010, 32'hC, 64'd0, 64'hDEAD_BEEF_0000_0000, 0, 0, rd, err, be, wd);
        n_checks++;
        if (rd !== 64'hFFFF_FFFF_DEAD_BEEF) begin
            n_fail++; $display("FAIL lw64: rdata=%h, want ffffffffdeadbeef", rd);
        end
        do_access(1, 0, 3'b010, 32'hC, 64'd0, 64'hDEAD_BEEF_0000_0000, 0, 1, rd, err, be, wd);
        n_checks++;
        if (rd !== 64'd0 || err !== 2'b10) begin
            n_fail++; $display("FAIL buserr64: rdata=%h err=%b, want 0 10", rd, err);
        end
    endtask

    task automatic test_random(input bit x64, input int n);
        logic [63:0] rd, wd;
        logic [1:0]  err;
        logic [7:0]  be;
        logic [2:0]  f;
        logic [31:0] addr;
        bit          we;
        int          r, delay;
        for (int i = 0; i < n; i++) begin
            we = bit'($urandom_range(0, 1));
            f  = 3'($urandom_range(0, 7));
            if (we) f[2] = 1'b0;
            addr = $urandom & 32'h0000_FFFF;
            if ($urandom_range(0, 2) != 0) addr = addr & ~((32'd1 << f[1:0]) - 32'd1);
            r = int'($urandom_range(0, 11));
            delay = (r < 9) ? r % 3 : r - 2;
            do_access(x64, we, f, addr, {$urandom, $urandom}, {$urandom, $urandom}, delay,
                      ($urandom_range(0, 7) == 0), rd, err, be, wd);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sel = 1'b0; reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct = '0;
        req_addr = '0; req_wdata = '0; mem_ready = 1'b0; mem_err = 1'b0; mem_rdata = '0;
        test_reset();
        test_directed32();
        test_timeout();
        test_reset_abort();
        test_directed64();
        test_random(1'b0, 60);
        test_random(1'b1, 60);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
